// File: rtl/type_char_encoder.sv
// ASCII instruction-type token parser: turns "R", "I", "IL", ... byte tokens
// back into 7-bit RISC-V opcodes, one registered result per token.
module type_char_encoder #(
  parameter bit CASE_FOLD = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       opcode,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] tok_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_J = 8'h4A;
  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_0 = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    GOT1,
    GOT2,
    FLUSH,
    OUT
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] c0;
  logic [7:0] c1;
  logic [7:0] c0_nx;
  logic [7:0] c1_nx;
  logic [7:0] ch;
  logic       acc;
  logic       term;
  logic       first_ok;
  logic       second_ok;
  logic       emit;
  logic [7:0] emit_res;

  // Result byte: bit 7 is the error flag, bits 6:0 the opcode.
  function automatic logic [7:0] decode(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    case ({a, b})
      {CH_R, CH_0}: r = {1'b0, 7'b0110011};
      {CH_I, CH_0}: r = {1'b0, 7'b0010011};
      {CH_I, CH_L}: r = {1'b0, 7'b0000011};
      {CH_S, CH_0}: r = {1'b0, 7'b0100011};
      {CH_B, CH_0}: r = {1'b0, 7'b1100011};
      {CH_J, CH_0}: r = {1'b0, 7'b1101111};
      {CH_I, CH_J}: r = {1'b0, 7'b1100111};
      {CH_U, CH_0}: r = {1'b0, 7'b0110111};
      default:      r = {1'b1, 7'b0000000};
    endcase
    return r;
  endfunction

  always_comb begin
    ch = in_data;
    if (CASE_FOLD && in_data >= 8'h61 && in_data <= 8'h7A) begin
      ch = in_data - 8'h20;
    end
  end

  assign acc  = in_valid & in_ready;
  assign term = (ch == 8'h20) || (ch == 8'h09) ||
                (ch == 8'h0D) || (ch == 8'h0A) ||
                (ch == 8'h2C);

  assign first_ok = (ch == CH_R) || (ch == CH_I) ||
                    (ch == CH_S) || (ch == CH_B) ||
                    (ch == CH_J) || (ch == CH_U);

  assign second_ok = (c0 == CH_I) &&
                     ((ch == CH_L) || (ch == CH_J));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    c0_nx    = c0;
    c1_nx    = c1;
    emit     = 1'b0;
    emit_res = 8'h00;
    unique case (state)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            term: state_nx = IDLE;
            first_ok: begin
              c0_nx    = ch;
              state_nx = GOT1;
            end
            default: state_nx = FLUSH;
          endcase
        end
      end
      GOT1: begin
        if (acc) begin
          unique case (1'b1)
            term: begin
              emit     = 1'b1;
              emit_res = decode(c0, CH_0);
              state_nx = OUT;
            end
            second_ok: begin
              c1_nx    = ch;
              state_nx = GOT2;
            end
            default: state_nx = FLUSH;
          endcase
        end
      end
      GOT2: begin
        if (acc) begin
          if (term) begin
            emit     = 1'b1;
            emit_res = decode(c0, c1);
            state_nx = OUT;
          end else begin
            state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (acc && term) begin
          emit     = 1'b1;
          emit_res = {1'b1, 7'b0000000};
          state_nx = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != OUT);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0      <= 8'h00;
      c1      <= 8'h00;
      opcode  <= 7'b0000000;
      out_err <= 1'b0;
    end else begin
      c0 <= c0_nx;
      c1 <= c1_nx;
      if (emit) begin
        opcode  <= emit_res[6:0];
        out_err <= emit_res[7];
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_count <= '0;
      err_count <= '0;
    end else if (emit) begin
      if (tok_count != '1) begin
        tok_count <= tok_count + 1'b1;
      end
      if (emit_res[7] && err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_type_char_encoder.sv
// Scoreboard bench for type_char_encoder: random token streams against a
// string-level token model; a second instance exercises counter saturation.
module tb_type_char_encoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] tok_count;
  logic [15:0] err_count;

  logic        s_in_ready;
  logic [6:0]  s_opcode;
  logic        s_err;
  logic        s_valid;
  logic [1:0]  s_tok;
  logic [1:0]  s_errc;

  type_char_encoder #(.CASE_FOLD(1'b1), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tok_count (tok_count),
    .err_count (err_count)
  );

  type_char_encoder #(.CASE_FOLD(1'b1), .CNT_W(2)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .opcode    (s_opcode),
    .out_err   (s_err),
    .out_valid (s_valid),
    .out_ready (out_ready),
    .tok_count (s_tok),
    .err_count (s_errc)
  );

  typedef struct {
    logic [6:0] op;
    logic       err;
    int         tok;
    int         errc;
  } exp_t;

  exp_t       sb[$];
  string      cur;
  logic [6:0] tbl[string];
  int         tok_m;
  int         err_m;
  int         checks;
  int         errors;
  bit         ready_rand;
  bit         gaps;
  string      vt[8];
  logic [7:0] terms[5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] m_fold(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  function automatic bit m_term(input logic [7:0] b);
    return b == 8'h20 || b == 8'h09 || b == 8'h0D ||
           b == 8'h0A || b == 8'h2C;
  endfunction

  // Token-level reference: collect the token text, look it up at the delimiter.
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (m_term(b)) begin
      if (cur.len() > 0) begin
        tok_m++;
        if (tbl.exists(cur)) begin
          e.op  = tbl[cur];
          e.err = 1'b0;
        end else begin
          e.op  = 7'b0;
          e.err = 1'b1;
          err_m++;
        end
        e.tok  = tok_m;
        e.errc = err_m;
        sb.push_back(e);
        cur = "";
      end
    end else begin
      cur = $sformatf("%s%c", cur, m_fold(b));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end else begin
      model_byte(b);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (out_valid === 1'b1);
    end
    chk("wait_valid", seen, 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_opcode", opcode, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tok_count", tok_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_small_tok", s_tok, 0);
    chk("rst_small_err", s_errc, 0);
    cur   = "";
    tok_m = 0;
    err_m = 0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] junk();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 255)); while (m_term(b));
    return b;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_token: op %b err %b", opcode, out_err);
        end else begin
          e = sb.pop_front();
          chk("opcode", opcode, e.op);
          chk("out_err", out_err, e.err);
          chk("tok_count", tok_count, sat(e.tok, 65535));
          chk("err_count", err_count, sat(e.errc, 65535));
          chk("small_tok", s_tok, sat(e.tok, 3));
          chk("small_err", s_errc, sat(e.errc, 3));
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : stim
    int k;
    logic [7:0] c;
    string s;
    checks = 0;
    errors = 0;
    cur    = "";
    tok_m  = 0;
    err_m  = 0;
    vt = '{"R", "I", "IL", "S", "B", "J", "IJ", "U"};
    terms = '{8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
    tbl["R"]  = 7'b0110011;
    tbl["I"]  = 7'b0010011;
    tbl["IL"] = 7'b0000011;
    tbl["S"]  = 7'b0100011;
    tbl["B"]  = 7'b1100011;
    tbl["J"]  = 7'b1101111;
    tbl["IJ"] = 7'b1100111;
    tbl["U"]  = 7'b0110111;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b1;
    ready_rand = 1'b0;
    gaps       = 1'b0;
    #2;
    do_reset();

    send_byte("R");
    send_byte(8'h0A);
    chk("latency_valid", out_valid, 1);
    chk("latency_opcode", opcode, 7'b0110011);
    drain();
    chk("first_tok_count", tok_count, 1);

    send_str("IL IJ i,");
    drain();
    chk("fold_err_count", err_count, 0);
    chk("fold_tok_count", tok_count, 4);

    send_str("ILX ");
    send_str("Q\n");
    send_str("U ");
    drain();
    chk("bad_err_count", err_count, 2);

    out_ready = 1'b0;
    send_str("B ");
    wait_valid();
    in_data  = "S";
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_opcode", opcode, 7'b1100011);
      chk("hold_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_byte("S");
    send_byte(" ");
    drain();

    ready_rand = 1'b1;
    gaps       = 1'b1;
    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 9);
      if (k < 6 || k == 8) begin
        s = vt[$urandom_range(0, 7)];
        for (int i = 0; i < s.len(); i++) begin
          c = s[i];
          if ($urandom_range(0, 1) == 1) c = c + 8'h20;
          send_byte(c);
        end
        if (k == 8) send_byte("X");
      end else if (k < 8) begin
        repeat ($urandom_range(1, 4)) send_byte(junk());
      end
      repeat ($urandom_range(1, 3)) send_byte(terms[$urandom_range(0, 4)]);
    end
    ready_rand = 1'b0;
    gaps       = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    send_byte("I");
    do_reset();
    out_ready = 1'b0;
    send_str("B ");
    wait_valid();
    @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;
    send_str("J ");
    drain();
    chk("post_reset_tok", tok_count, 1);

    repeat (6) send_str("Q ");
    drain();
    chk("sat_small_err", s_errc, 3);
    chk("sat_small_tok", s_tok, 3);
    chk("wide_err_count", err_count, 6);
    chk("wide_tok_count", tok_count, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
